// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational memory port between an instruction-fetch
// port and a load/store data port, with round-robin arbitration and one
// transaction in flight at a time (grant -> access -> response).
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] i_rsp_data,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [1:0]        d_req_size,
    input  logic              d_req_unsigned,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_err,
    output logic [3:0]        mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {PORT_FETCH, PORT_DATA} port_t;

    state_t              state, state_next;
    port_t               last_grant;
    port_t               grant_port;
    logic                grant_fetch, grant_data;
    logic                rsp_handshake;

    logic                lat_we;
    logic [1:0]          lat_size;
    logic                lat_unsigned;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;

    logic [3:0]          store_mask;
    logic [DATA_W-1:0]   load_data;
    logic                size_bad;

    // Round-robin grant in IDLE: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (!rst && state == IDLE) begin
            if (i_req_valid && d_req_valid) begin
                grant_fetch = (last_grant == PORT_DATA);
                grant_data  = (last_grant == PORT_FETCH);
            end else begin
                grant_fetch = i_req_valid;
                grant_data  = d_req_valid;
            end
        end
    end

    assign rsp_handshake = (state == RESP) &&
                           ((grant_port == PORT_FETCH) ? i_rsp_ready : d_rsp_ready);

    // Next-state: IDLE -> ACCESS on any grant, ACCESS -> RESP always, RESP -> IDLE on handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_fetch || grant_data) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Size decode: byte-lane enables for stores and extended load data from the raw word.
    always_comb begin
        store_mask = 4'b0000;
        load_data  = '0;
        size_bad   = (lat_size == 2'b11);
        case (lat_size)
            2'b00: begin
                store_mask = 4'b0001;
                load_data  = {{24{~lat_unsigned & mem_rdata[7]}}, mem_rdata[7:0]};
            end
            2'b01: begin
                store_mask = 4'b0011;
                load_data  = {{16{~lat_unsigned & mem_rdata[15]}}, mem_rdata[15:0]};
            end
            2'b10: begin
                store_mask = 4'b1111;
                load_data  = mem_rdata;
            end
            default: ;
        endcase
    end

    // Memory drive: only the ACCESS cycle touches the memory, and only legal stores write.
    always_comb begin
        mem_write = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst && state == ACCESS) begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            if (grant_port == PORT_DATA && lat_we) mem_write = store_mask;
        end
    end

    assign i_req_ready = grant_fetch;
    assign d_req_ready = grant_data;
    assign i_rsp_valid = !rst && state == RESP && grant_port == PORT_FETCH;
    assign d_rsp_valid = !rst && state == RESP && grant_port == PORT_DATA;
    assign i_rsp_data  = i_rsp_valid ? rsp_data_q : '0;
    assign d_rsp_data  = d_rsp_valid ? rsp_data_q : '0;
    assign d_rsp_err   = d_rsp_valid && rsp_err_q;

    // State, request latch, captured response and last_grant; synchronous reset clears all of it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= IDLE;
            last_grant   <= PORT_DATA;
            grant_port   <= PORT_FETCH;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_fetch) begin
                grant_port   <= PORT_FETCH;
                lat_we       <= 1'b0;
                lat_size     <= 2'b10;
                lat_unsigned <= 1'b1;
                lat_addr     <= i_req_addr;
                lat_wdata    <= '0;
            end else if (grant_data) begin
                grant_port   <= PORT_DATA;
                lat_we       <= d_req_we;
                lat_size     <= d_req_size;
                lat_unsigned <= d_req_unsigned;
                lat_addr     <= d_req_addr;
                lat_wdata    <= d_req_wdata;
            end
            if (state == ACCESS) begin
                if (grant_port == PORT_FETCH) begin
                    rsp_data_q <= mem_rdata;
                    rsp_err_q  <= 1'b0;
                end else begin
                    rsp_data_q <= (lat_we || size_bad) ? '0 : load_data;
                    rsp_err_q  <= size_bad;
                end
            end
            if (rsp_handshake) last_grant <= grant_port;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model and a byte-array memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
    logic [15:0] i_req_addr;
    logic [31:0] i_rsp_data;
    logic        d_req_valid, d_req_we, d_req_unsigned, d_req_ready;
    logic [1:0]  d_req_size;
    logic [15:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_rsp_data;
    logic [3:0]  mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [7:0]  mem [0:65535];

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_size(d_req_size),
        .d_req_unsigned(d_req_unsigned), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: combinational little-endian read, byte-lane writes on the rising edge.
    logic [15:0] a1, a2, a3;
    assign a1 = mem_addr + 16'd1;
    assign a2 = mem_addr + 16'd2;
    assign a3 = mem_addr + 16'd3;
    assign mem_rdata = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};

    always @(posedge clk) begin
        if (mem_write[0]) mem[mem_addr] <= mem_wdata[7:0];
        if (mem_write[1]) mem[a1]       <= mem_wdata[15:8];
        if (mem_write[2]) mem[a2]       <= mem_wdata[23:16];
        if (mem_write[3]) mem[a3]       <= mem_wdata[31:24];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        is_data;
        bit        we;
        bit [1:0]  size;
        bit        uns;
        bit [15:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_data;
        bit        exp_err;
    } txn_t;

    txn_t m_txn;
    bit   m_busy = 0;
    int   m_phase = 0;       // cycles since grant: 1 = memory access, 2 = response
    bit   m_last_data = 1;
    bit   i_acc = 0, d_acc = 0;

    function automatic logic [31:0] rd_word(input logic [15:0] a);
        logic [31:0] w;
        logic [15:0] b;
        w = 0;
        for (int k = 0; k < 4; k++) begin
            b = a + 16'(k);
            w[8*k +: 8] = mem[b];
        end
        return w;
    endfunction

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] size, input bit uns);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = w % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = w % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [1:0] size);
        int n;
        if (size == 2'd3) return 4'b0000;
        n = 1 << size;
        return 4'((1 << n) - 1);
    endfunction

    // Compare process: checks every output mid-cycle against the model, then advances the model.
    always @(negedge clk) begin
        bit gf, gd;
        i_acc = 0;
        d_acc = 0;
        if (rst) begin
            check("rst_i_req_ready", i_req_ready, 0);
            check("rst_d_req_ready", d_req_ready, 0);
            check("rst_i_rsp_valid", i_rsp_valid, 0);
            check("rst_d_rsp_valid", d_rsp_valid, 0);
            check("rst_i_rsp_data", i_rsp_data, 0);
            check("rst_d_rsp_data", d_rsp_data, 0);
            check("rst_d_rsp_err", d_rsp_err, 0);
            check("rst_mem_write", mem_write, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            m_busy = 0;
            m_last_data = 1;
        end else if (!m_busy) begin
            gf = i_req_valid && (!d_req_valid || m_last_data);
            gd = d_req_valid && (!i_req_valid || !m_last_data);
            check("idle_i_req_ready", i_req_ready, gf);
            check("idle_d_req_ready", d_req_ready, gd);
            check("idle_i_rsp_valid", i_rsp_valid, 0);
            check("idle_d_rsp_valid", d_rsp_valid, 0);
            check("idle_mem_write", mem_write, 0);
            i_acc = i_req_valid && i_req_ready;
            d_acc = d_req_valid && d_req_ready;
            if (gf || gd) begin
                m_txn.is_data = gd;
                m_txn.we      = gd ? d_req_we : 1'b0;
                m_txn.size    = gd ? d_req_size : 2'd2;
                m_txn.uns     = gd ? d_req_unsigned : 1'b1;
                m_txn.addr    = gd ? d_req_addr : i_req_addr;
                m_txn.wdata   = gd ? d_req_wdata : 32'h0;
                m_busy  = 1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            check("acc_i_req_ready", i_req_ready, 0);
            check("acc_d_req_ready", d_req_ready, 0);
            check("acc_i_rsp_valid", i_rsp_valid, 0);
            check("acc_d_rsp_valid", d_rsp_valid, 0);
            check("acc_mem_addr", mem_addr, m_txn.addr);
            check("acc_mem_write", mem_write, m_txn.we ? exp_mask(m_txn.size) : 4'b0000);
            if (m_txn.we) check("acc_mem_wdata", mem_wdata, m_txn.wdata);
            m_txn.exp_err  = m_txn.is_data && m_txn.size == 2'd3;
            if (m_txn.exp_err || m_txn.we) m_txn.exp_data = 0;
            else m_txn.exp_data = ext_load(rd_word(m_txn.addr), m_txn.size, m_txn.uns);
            m_phase = 2;
        end else begin
            check("rsp_i_req_ready", i_req_ready, 0);
            check("rsp_d_req_ready", d_req_ready, 0);
            check("rsp_mem_write", mem_write, 0);
            check("rsp_i_rsp_valid", i_rsp_valid, !m_txn.is_data);
            check("rsp_d_rsp_valid", d_rsp_valid, m_txn.is_data);
            if (m_txn.is_data) begin
                check("rsp_d_rsp_data", d_rsp_data, m_txn.exp_data);
                check("rsp_d_rsp_err", d_rsp_err, m_txn.exp_err);
            end else begin
                check("rsp_i_rsp_data", i_rsp_data, m_txn.exp_data);
            end
            if (m_txn.is_data ? d_rsp_ready : i_rsp_ready) begin
                m_busy = 0;
                m_last_data = m_txn.is_data;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit is_data, output bit got);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); #1;
            got = is_data ? d_req_ready : i_req_ready;
        end
        if (!got) check(is_data ? "d_grant_timeout" : "i_grant_timeout", 0, 1);
    endtask

    task automatic data_txn(input bit we, input bit [1:0] size, input bit uns,
                            input bit [15:0] addr, input bit [31:0] wdata,
                            output bit [31:0] data, output bit err, output int wr_cycles);
        bit got;
        data = 0; err = 0; wr_cycles = 0;
        @(posedge clk); #1;
        d_req_valid = 1; d_req_we = we; d_req_size = size; d_req_unsigned = uns;
        d_req_addr = addr; d_req_wdata = wdata; d_rsp_ready = 1;
        wait_ready(1, got);
        @(posedge clk); #1;
        d_req_valid = 0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); #1;
            if (mem_write != 4'b0000) wr_cycles++;
            if (d_rsp_valid) begin got = 1; data = d_rsp_data; err = d_rsp_err; end
        end
        if (!got) check("d_rsp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit [31:0] data, cap;
        bit        err, got;
        int        wr, n;
        bit        order [4];
        int        t [4];

        for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
        rst = 1;
        i_req_valid = 0; i_req_addr = 0; i_rsp_ready = 1;
        d_req_valid = 0; d_req_we = 0; d_req_size = 0; d_req_unsigned = 0;
        d_req_addr = 0; d_req_wdata = 0; d_rsp_ready = 1;
        step(3);
        rst = 0;

        // Simultaneous requests after reset: fetch first, then alternate; grants 3 cycles apart.
        i_req_valid = 1; i_req_addr = 16'h0020;
        d_req_valid = 1; d_req_we = 0; d_req_size = 2; d_req_addr = 16'h0040;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk); #1;
            if (i_req_ready)      begin order[n] = 0; t[n] = c; n++; end
            else if (d_req_ready) begin order[n] = 1; t[n] = c; n++; end
        end
        if (n < 4) check("rr_grant_timeout", n, 4);
        else begin
            check("rr_grant0_fetch", order[0], 0);
            check("rr_grant1_data", order[1], 1);
            check("rr_grant2_fetch", order[2], 0);
            check("rr_grant3_data", order[3], 1);
            check("rr_grant_spacing", t[1] - t[0], 3);
        end
        @(posedge clk); #1;
        i_req_valid = 0; d_req_valid = 0;
        step(5);

        // Fetch only: ready at T, memory access at T+1, response at T+2.
        {mem[16'h0013], mem[16'h0012], mem[16'h0011], mem[16'h0010]} = 32'hDEADBEEF;
        i_req_valid = 1; i_req_addr = 16'h0010;
        @(negedge clk); #1;
        check("fetch_ready_T", i_req_ready, 1);
        @(posedge clk); #1;
        i_req_valid = 0;
        @(negedge clk); #1;
        check("fetch_T1_mem_addr", mem_addr, 16'h0010);
        check("fetch_T1_mem_write", mem_write, 0);
        check("fetch_T1_no_rsp", i_rsp_valid, 0);
        @(negedge clk); #1;
        check("fetch_T2_rsp_valid", i_rsp_valid, 1);
        check("fetch_T2_rsp_data", i_rsp_data, 32'hDEADBEEF);
        step(2);

        // Byte store then signed/unsigned readback.
        mem[16'h0103] = 8'h00; mem[16'h0104] = 8'h77;
        data_txn(1, 2'd0, 0, 16'h0103, 32'h000000A5, data, err, wr);
        check("sb_write_cycles", wr, 1);
        check("sb_rsp_data", data, 0);
        check("sb_rsp_err", err, 0);
        check("sb_mem_byte", mem[16'h0103], 8'hA5);
        check("sb_mem_next_untouched", mem[16'h0104], 8'h77);
        data_txn(0, 2'd0, 0, 16'h0103, 0, data, err, wr);
        check("lb_signed", data, 32'hFFFFFFA5);
        data_txn(0, 2'd0, 1, 16'h0103, 0, data, err, wr);
        check("lb_unsigned", data, 32'h000000A5);
        data_txn(0, 2'd1, 0, 16'h0103, 0, data, err, wr);
        check("lh_signed_positive", data, 32'h000077A5);

        // Address wrap at the top of the address space.
        mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
        data_txn(0, 2'd2, 0, 16'hFFFE, 0, data, err, wr);
        check("lw_wrap", data, 32'h44332211);

        // Illegal size store and load.
        data_txn(1, 2'd3, 0, 16'h0300, 32'hFFFFFFFF, data, err, wr);
        check("bad_store_writes", wr, 0);
        check("bad_store_err", err, 1);
        check("bad_store_data", data, 0);
        data_txn(0, 2'd3, 0, 16'h0300, 0, data, err, wr);
        check("bad_load_err", err, 1);
        check("bad_load_data", data, 0);

        // Backpressure on the data response while fetch waits.
        {mem[16'h0403], mem[16'h0402], mem[16'h0401], mem[16'h0400]} = 32'hCAFEF00D;
        d_rsp_ready = 0;
        d_req_valid = 1; d_req_we = 0; d_req_size = 2; d_req_unsigned = 0; d_req_addr = 16'h0400;
        wait_ready(1, got);
        @(posedge clk); #1;
        d_req_valid = 0;
        i_req_valid = 1; i_req_addr = 16'h0010;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk); #1;
            got = d_rsp_valid;
        end
        if (!got) check("bp_rsp_timeout", 0, 1);
        cap = d_rsp_data;
        check("bp_rsp_data", cap, 32'hCAFEF00D);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("bp_hold_valid", d_rsp_valid, 1);
            check("bp_hold_data", d_rsp_data, cap);
            check("bp_no_fetch_grant", i_req_ready, 0);
        end
        @(posedge clk); #1;
        d_rsp_ready = 1;
        wait_ready(0, got);
        @(posedge clk); #1;
        i_req_valid = 0;
        step(4);

        // Reset during the access cycle of a store.
        mem[16'h0500] = 8'h11;
        d_req_valid = 1; d_req_we = 1; d_req_size = 0; d_req_addr = 16'h0500; d_req_wdata = 32'h5A;
        wait_ready(1, got);
        @(posedge clk); #1;
        d_req_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check("post_rst_no_rsp", d_rsp_valid, 0);
        end
        data_txn(0, 2'd0, 1, 16'h0500, 0, data, err, wr);
        check("post_rst_load", data, 32'h00000011);

        // Randomized traffic with occasional resets and response backpressure.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 99) == 0);
            if (i_acc || !i_req_valid) begin
                i_req_valid = $urandom_range(0, 1) == 1;
                i_req_addr  = 16'($urandom);
            end
            if (d_acc || !d_req_valid) begin
                d_req_valid    = $urandom_range(0, 1) == 1;
                d_req_we       = $urandom_range(0, 1) == 1;
                d_req_size     = 2'($urandom_range(0, 3));
                d_req_unsigned = $urandom_range(0, 1) == 1;
                d_req_addr     = 16'($urandom);
                d_req_wdata    = $urandom;
            end
            i_rsp_ready = $urandom_range(0, 3) != 0;
            d_rsp_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk); #1;
        rst = 0; i_req_valid = 0; d_req_valid = 0; i_rsp_ready = 1; d_rsp_ready = 1;
        step(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
